// File: rtl/iqd_pkg.sv
// -----------------------------------------------------------------------------
// iqd_pkg
// Shared definitions for the instruction queue / decode block:
//   - MIPS opcode constants that affect decoding
//   - bit positions of the instruction fields
//   - dec_t, the packed set of decoded fields
//   - decode_fields(), used by both output-stage load paths (queue head and
//     the optional bypass selected by IQD_BYPASS_EN in instr_queue_decode)
// PCs are passed in at PC_MAX_W bits so one function serves any PC_W up to
// PC_MAX_W; the caller keeps the low PC_W bits of jump_target.
// -----------------------------------------------------------------------------
package iqd_pkg;

   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_ANDI = 6'h0C;
   localparam logic [5:0] OP_ORI  = 6'h0D;
   localparam logic [5:0] OP_XORI = 6'h0E;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_LSB    = 0;
   localparam int TARGET_LSB = 0;

   localparam int PC_MAX_W = 64;

   typedef struct packed {
      logic [5:0]          opcode;
      logic [4:0]          rs;
      logic [4:0]          rt;
      logic [4:0]          rd;
      logic [4:0]          shamt;
      logic [5:0]          funct;
      logic [31:0]         imm_ext;
      logic [PC_MAX_W-1:0] jump_target;
   } dec_t;

   function automatic dec_t decode_fields(input logic [31:0]         instr,
                                          input logic [PC_MAX_W-1:0] pc);
      dec_t                d;
      logic [15:0]         imm;
      logic [PC_MAX_W-1:0] pc4;
      d.opcode = instr[OPCODE_LSB +: 6];
      d.rs     = instr[RS_LSB     +: 5];
      d.rt     = instr[RT_LSB     +: 5];
      d.rd     = instr[RD_LSB     +: 5];
      d.shamt  = instr[SHAMT_LSB  +: 5];
      d.funct  = instr[FUNCT_LSB  +: 6];
      imm      = instr[IMM_LSB    +: 16];
      // Logical immediates are zero-extended; everything else sign-extends.
      if (d.opcode inside {OP_ANDI, OP_ORI, OP_XORI})
         d.imm_ext = {16'h0000, imm};
      else
         d.imm_ext = {{16{imm[15]}}, imm};
      // pc < 2^PC_W, so any carry out of pc+4 lands above bit PC_W-1 and is
      // dropped when the caller truncates: this is pc+4 modulo 2^PC_W.
      pc4 = pc + PC_MAX_W'(4);
      d.jump_target = {pc4[PC_MAX_W-1:28], instr[TARGET_LSB +: 26], 2'b00};
      return d;
   endfunction

endpackage

// File: rtl/iqd_fifo.sv
// -----------------------------------------------------------------------------
// iqd_fifo
// Synchronous DEPTH-entry queue of W-bit words with read/write pointers and an
// occupancy counter. Pushes while full and pops while empty are ignored.
// flush (and rst) clears pointers and count; stored words are left as they are.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   flush       synchronous clear of pointers and count
//   push, data  write data at the write pointer
//   pop         advance the read pointer
//   head        word at the read pointer (valid while count != 0)
//   count       number of stored entries
// -----------------------------------------------------------------------------
module iqd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [W-1:0]     data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != CNT_W'(DEPTH));
   assign do_pop  = pop  && (count != '0);

   // NOTE: sequential state is assigned with <= so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap.
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)
            count <= count + CNT_W'(1);
         else if (do_pop && !do_push)
            count <= count - CNT_W'(1);
      end
   end

   // NOTE: the storage array has no reset; count guards every read, so its
   // contents never matter while empty, and it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush)
         mem[wr_ptr] <= data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_queue_decode.sv
// -----------------------------------------------------------------------------
// instr_queue_decode
// Buffers fetched MIPS instructions with their PC in a DEPTH-entry queue and
// presents one decoded instruction at a time from a registered output stage.
// Optional feature: define IQD_BYPASS_EN to let a push into an empty queue
// with a free output stage load the output stage directly (0-cycle latency).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            fetch handshake; in_instr, in_pc payload
//   flush                        drop queue and output stage (fields kept)
//   out_valid/out_ready          consumer handshake
//   opcode..funct, imm_ext       decoded fields of the output instruction
//   jump_target                  {pc4[PC_W-1:28], instr[25:0], 2'b00}
//   out_pc                       PC of the output instruction
//   count                        queue occupancy, output stage excluded
// -----------------------------------------------------------------------------
module instr_queue_decode
   import iqd_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   input  logic             flush,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [31:0]      imm_ext,
   output logic [PC_W-1:0]  jump_target,
   output logic [PC_W-1:0]  out_pc,
   output logic [CNT_W-1:0] count
);

   localparam int ENTRY_W = 32 + PC_W;

   logic                push;
   logic                can_load;
   logic                pop;
   logic                bypass;
   logic                load;
   logic [ENTRY_W-1:0]  head;
   logic [31:0]         sel_instr;
   logic [PC_W-1:0]     sel_pc;
   logic [PC_MAX_W-1:0] sel_pc_ext;
   dec_t                sel_dec;

   // Depends on registered count only: no out_ready -> in_ready path.
   assign in_ready = (count != CNT_W'(DEPTH));
   assign push     = in_valid && in_ready;
   assign can_load = !out_valid || out_ready;
   assign pop      = can_load && (count != '0);

`ifdef IQD_BYPASS_EN
   assign bypass = push && can_load && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign load = pop || bypass;

   iqd_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (push && !bypass),
      .data  ({in_instr, in_pc}),
      .pop   (pop),
      .head  (head),
      .count (count)
   );

   // NOTE: every variable written here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      sel_instr  = head[ENTRY_W-1 -: 32];
      sel_pc     = head[PC_W-1:0];
      if (bypass) begin
         sel_instr = in_instr;
         sel_pc    = in_pc;
      end
      sel_pc_ext             = '0;
      sel_pc_ext[PC_W-1:0]   = sel_pc;
      sel_dec                = decode_fields(sel_instr, sel_pc_ext);
   end

   // Priority: rst, then flush, then load, then drain of an empty stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         opcode      <= '0;
         rs          <= '0;
         rt          <= '0;
         rd          <= '0;
         shamt       <= '0;
         funct       <= '0;
         imm_ext     <= '0;
         jump_target <= '0;
         out_pc      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid   <= 1'b1;
         opcode      <= sel_dec.opcode;
         rs          <= sel_dec.rs;
         rt          <= sel_dec.rt;
         rd          <= sel_dec.rd;
         shamt       <= sel_dec.shamt;
         funct       <= sel_dec.funct;
         imm_ext     <= sel_dec.imm_ext;
         jump_target <= sel_dec.jump_target[PC_W-1:0];
         out_pc      <= sel_pc;
      end else if (can_load) begin
         // Output consumed with nothing queued: fields hold their values.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_instr_queue_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_queue_decode
// Reference model: a queue of {instr, pc} items plus one output slot; the
// expected fields are recomputed from the slot's instruction with plain
// shifts and masks. Directed sequences pin the model with literal values,
// then randomized traffic (pushes, stalls, flushes, resets) follows.
// -----------------------------------------------------------------------------
module tb_instr_queue_decode;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [PC_W-1:0]  in_pc;
   logic             flush;
   logic             out_ready;
   logic             out_valid;
   logic [5:0]       opcode;
   logic [4:0]       rs, rt, rd, shamt;
   logic [5:0]       funct;
   logic [31:0]      imm_ext;
   logic [PC_W-1:0]  jump_target;
   logic [PC_W-1:0]  out_pc;
   logic [CNT_W-1:0] count;

   instr_queue_decode #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
      .shamt(shamt), .funct(funct), .imm_ext(imm_ext),
      .jump_target(jump_target), .out_pc(out_pc), .count(count)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } item_t;

   item_t       q[$];
   bit          m_valid = 1'b0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc    = '0;
   bit          chk_en  = 1'b0;

   function automatic logic [31:0] ref_imm(input logic [31:0] instr);
      logic [31:0] lo;
      int          op;
      lo = instr & 32'h0000_FFFF;
      op = int'(instr >> 26);
      if (op == 12 || op == 13 || op == 14) return lo;
      return (lo ^ 32'h0000_8000) - 32'h0000_8000;
   endfunction

   function automatic logic [31:0] ref_jump(input logic [31:0] instr, input logic [31:0] pc);
      return ((pc + 32'd4) & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
   endfunction

   task automatic model_step(input bit r, input bit fl, input bit iv,
                             input logic [31:0] ins, input logic [31:0] pc, input bit ordy);
      bit accept;
      bit free;
      item_t it;
      if (r) begin
         q.delete();
         m_valid = 1'b0;
         m_instr = '0;
         m_pc    = '0;
      end else if (fl) begin
         q.delete();
         m_valid = 1'b0;
      end else begin
         accept = iv && (q.size() < DEPTH);
         free   = !m_valid || ordy;
         if (free) begin
            if (q.size() > 0) begin
               it      = q.pop_front();
               m_instr = it.instr;
               m_pc    = it.pc;
               m_valid = 1'b1;
`ifdef IQD_BYPASS_EN
            end else if (accept) begin
               m_instr = ins;
               m_pc    = pc;
               m_valid = 1'b1;
               accept  = 1'b0;
`endif
            end else begin
               m_valid = 1'b0;
            end
         end
         if (accept) begin
            it.instr = ins;
            it.pc    = pc;
            q.push_back(it);
         end
      end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid",   out_valid,   m_valid);
         check("count",       count,       q.size());
         check("in_ready",    in_ready,    q.size() < DEPTH);
         check("opcode",      opcode,      m_instr >> 26);
         check("rs",          rs,          (m_instr >> 21) & 32'h1F);
         check("rt",          rt,          (m_instr >> 16) & 32'h1F);
         check("rd",          rd,          (m_instr >> 11) & 32'h1F);
         check("shamt",       shamt,       (m_instr >> 6)  & 32'h1F);
         check("funct",       funct,       m_instr & 32'h3F);
         check("imm_ext",     imm_ext,     ref_imm(m_instr));
         check("jump_target", jump_target, ref_jump(m_instr, m_pc));
         check("out_pc",      out_pc,      m_pc);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycle(input bit r, input bit iv, input logic [31:0] ins,
                        input logic [31:0] pc, input bit fl, input bit ordy);
      rst = r; in_valid = iv; in_instr = ins; in_pc = pc; flush = fl; out_ready = ordy;
      @(posedge clk);
      model_step(r, fl, iv, ins, pc, ordy);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 3))
         0: v[31:26] = 6'h0C + 6'($urandom_range(0, 2));
         1: v[31:26] = 6'h02;
         default: ;
      endcase
      return v;
   endfunction

   initial begin
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      check("reset out_valid", out_valid, 0);
      check("reset count",     count,     0);
      check("reset in_ready",  in_ready,  1);

      // Load word: 0x8C220004 at 0x00400000.
      cycle(0, 1, 32'h8C22_0004, 32'h0040_0000, 0, 1);
`ifdef IQD_BYPASS_EN
      check("bypass out_valid", out_valid, 1);
      check("bypass count",     count,     0);
`else
      check("latency out_valid", out_valid, 0);
      check("latency count",     count,     1);
`endif
      cycle(0, 0, 0, 0, 0, 0);
      check("lw out_valid", out_valid, 1);
      check("lw opcode",    opcode,    6'h23);
      check("lw rs",        rs,        1);
      check("lw rt",        rt,        2);
      check("lw imm_ext",   imm_ext,   32'h0000_0004);
      check("lw out_pc",    out_pc,    32'h0040_0000);
      cycle(0, 0, 0, 0, 0, 1);

      // ori zero-extends, addi sign-extends.
      cycle(0, 1, 32'h3421_FFFF, 32'h0040_0004, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      check("ori imm_ext", imm_ext, 32'h0000_FFFF);
      cycle(0, 1, 32'h2021_FFFF, 32'h0040_0008, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      check("addi imm_ext", imm_ext, 32'hFFFF_FFFF);
      cycle(0, 0, 0, 0, 0, 1);

      // Jump across a 256 MB region boundary.
      cycle(0, 1, 32'h0810_0010, 32'h1FFF_FFFC, 0, 1);
      cycle(0, 0, 0, 0, 0, 0);
      check("j jump_target", jump_target, 32'h2040_0040);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);

      // Fill while stalled: one in the output stage, DEPTH queued, extra refused.
      for (int i = 0; i < DEPTH + 1; i++)
         cycle(0, 1, 32'h2000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i), 0, 0);
      check("full count",    count,    DEPTH);
      check("full in_ready", in_ready, 0);
      cycle(0, 1, 32'h2000_00EE, 32'h0000_2000, 0, 0);
      check("refused count", count, DEPTH);
      for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 0, 0, 1);
      check("drained out_valid", out_valid, 0);
      check("drained count",     count,     0);

      // Flush with 3 queued and a simultaneous push.
      for (int i = 0; i < 4; i++)
         cycle(0, 1, 32'h2400_0000 + 32'(i), 32'h0000_3000 + 32'(4 * i), 0, 0);
      check("preflush count", count, 3);
      cycle(0, 1, 32'h2400_00FF, 32'h0000_3100, 1, 0);
      check("flush count",     count,     0);
      check("flush out_valid", out_valid, 0);
      check("flush in_ready",  in_ready,  1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, rand_instr(),
               $urandom, $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 6);

      // Reset mid-stream.
      for (int i = 0; i < 3; i++) cycle(0, 1, rand_instr(), $urandom, 0, 0);
      cycle(1, 1, rand_instr(), $urandom, 0, 0);
      check("rst out_valid",   out_valid,   0);
      check("rst count",       count,       0);
      check("rst in_ready",    in_ready,    1);
      check("rst opcode",      opcode,      0);
      check("rst imm_ext",     imm_ext,     0);
      check("rst jump_target", jump_target, 0);
      check("rst out_pc",      out_pc,      0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_queue_decode.md
Name: instr_queue_decode

Overview:
Parametrised successor to the single-stage instruction register. Buffers fetched MIPS instructions with their PC in a DEPTH-entry queue and presents one decoded instruction at a time from a registered output stage. Uses a valid/ready handshake on both sides and a synchronous flush for branches and jumps. Sits between the fetch unit and the control/register-file stage.

Parameters:
DEPTH, 4, queue entries; a power of 2, at least 2.
PC_W, 32, PC width; the instruction width is fixed at 32.
CNT_W, $clog2(DEPTH+1), width of the occupancy counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept
in_instr  in  32  instruction word
in_pc  in  PC_W  address of in_instr
flush  in  1  discard all queued and output-stage contents
out_ready  in  1  consumer takes the current output
out_valid  out  1  decoded fields are valid
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
funct  out  6  instr[5:0]
imm_ext  out  32  extended instr[15:0]
jump_target  out  PC_W  {pc4[PC_W-1:28], instr[25:0], 2'b00}, where pc4 = pc+4
out_pc  out  PC_W  PC of the output instruction
count  out  CNT_W  queue occupancy, excluding the output stage

Behaviour:
- Reset: rst is sampled on the clk edge. All outputs go to 0, out_valid=0, count=0, in_ready=1, and the pointers clear. Reset mid-stream drops everything.
- Push: occurs when in_valid and in_ready are high at an edge. Write the pair {in_instr, in_pc} at the write pointer.
- in_ready = (count != DEPTH). It is derived from registered count only, so there is no path from out_ready to in_ready.
- Output-stage load condition: (!out_valid || out_ready) and count != 0. On load:
  - pop the head;
  - register all decoded fields;
  - set out_valid=1.
- If the load condition holds with count==0, out_valid drops to 0 and the fields hold their last values.
- Latency: an instruction pushed at edge N into an empty queue with a free output stage is visible at edge N+1 (out_valid high after N+1).
- Push and pop on the same edge: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- The full state refuses pushes.
- An empty queue never underflows.
- Fields are held stable while out_valid && !out_ready.
- imm_ext:
  - zero-extended when opcode is 6'h0C (andi), 6'h0D (ori) or 6'h0E (xori);
  - otherwise sign-extended from bit 15.
- jump_target uses pc4 = stored pc + 4, modulo 2^PC_W.
- flush:
  - has priority over push, pop and load at the same edge;
  - clears pointers, count and out_valid;
  - discards any input pushed that cycle;
  - leaves field registers unchanged;
  - on the next cycle in_ready=1.
- rst has priority over flush.

Optional Feature:
Macro IQD_BYPASS_EN.
- Defined: when count==0, the output stage is loadable and a push occurs (no flush), the input is decoded straight into the output stage at that edge and is not written to the queue. Latency becomes 0 cycles, i.e. visible right after the push edge N.
- Undefined: every instruction passes through the queue, giving the 1-cycle latency described above.

Decomposition:
- Package iqd_pkg:
  - opcode constants (OP_ANDI, OP_ORI, OP_XORI, OP_J, OP_JAL);
  - field bit-position localparams;
  - a packed struct for the decoded fields;
  - a function decode_fields(instr, pc) used by both load paths.
- Sub-module iqd_fifo: a synchronous DEPTH x (32+PC_W) queue with pointers and count. It exposes a push/pop/flush/head/count interface. The top level holds the output stage and the bypass.

Test Plan:
- Reset, then push 0x8C220004 at pc 0x00400000 with out_ready=1 -> next cycle out_valid=1, opcode=0x23, rs=1, rt=2, imm_ext=0x00000004, out_pc=0x00400000.
- Push 0x3421FFFF (ori) then 0x2021FFFF (addi) -> imm_ext=0x0000FFFF, then 0xFFFFFFFF.
- Hold out_ready=0 and push DEPTH+1 instructions -> count saturates at DEPTH, in_ready=0 and the extra push is refused. Release out_ready -> outputs appear in order with no loss or duplication across the pointer wrap.
- Push 0x08100010 at pc 0x1FFFFFFC -> jump_target=0x20400040.
- With 3 queued, assert flush together with in_valid -> next cycle count=0, out_valid=0, in_ready=1, and no flushed instruction ever appears.
- With IQD_BYPASS_EN defined, push into an empty queue -> out_valid=1 immediately after that edge, count stays 0. Assert rst mid-stream -> all outputs 0.
